// File: rtl/dsc_s2b_frame_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dsc_s2b_frame_if
// Brief    : Handshake/data bundle between a stochastic stream producer and
//            the framed stochastic-to-binary receiver.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface dsc_s2b_frame_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic                 sn_in;
  logic                 sn_valid;
  logic                 early_stop;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] z;
  logic                 sat;
  logic                 early;

  // Producer / controller side
  modport master (
    output start, sn_in, sn_valid, early_stop,
    input  busy, done, z, sat, early
  );

  // Receiver side
  modport slave (
    input  start, sn_in, sn_valid, early_stop,
    output busy, done, z, sat, early
  );
endinterface
`default_nettype wire

// File: rtl/dsc_s2b_frame.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dsc_s2b_frame
// Brief    : Framed stochastic-to-binary receiver. Counts ones over one
//            deterministic frame of 2^CNT_WIDTH accepted bits, or fewer when
//            the producer signals early shutoff, then reports the count with
//            a one-cycle done pulse.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dsc_s2b_frame #(
  parameter int SNG_WIDTH  = 8,
  parameter int NUM_INPUTS = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,      // asynchronous, active low
  dsc_s2b_frame_if.slave  bus
);

  localparam int CNT_WIDTH = NUM_INPUTS * SNG_WIDTH;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_bit_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_bit_cnt;
  logic [CNT_WIDTH:0]   r_ones_cnt;   // one extra bit so an all-ones frame does not wrap
  logic [CNT_WIDTH-1:0] r_z;
  logic                 r_sat;
  logic                 r_early;

  logic                 w_run;
  logic                 w_accept;
  logic                 w_last_bit;
  logic                 w_stop;
  logic                 w_term;
  logic [CNT_WIDTH:0]   w_ones_final;

  // Qualifiers are gated by RUN so unknown inputs outside a frame stay inert.
  assign w_run        = (r_state == c_st_run);
  assign w_accept     = w_run & bus.sn_valid;
  assign w_last_bit   = w_accept & (r_bit_cnt == {CNT_WIDTH{1'b1}});
  assign w_stop       = w_run & bus.early_stop;
  assign w_term       = w_last_bit | w_stop;
  // Count including the bit accepted this cycle (also counted on early stop).
  assign w_ones_final = r_ones_cnt + {{CNT_WIDTH{1'b0}}, (w_accept & bus.sn_in)};

  // Frame sequencing: IDLE -> RUN on start, RUN -> DONE on terminal cycle, DONE -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (bus.start) r_state <= c_st_run;
        c_st_run:  if (w_term)    r_state <= c_st_done;
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  // Bit and ones counters: cleared on an accepted start, advanced on accepted bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if ((r_state == c_st_idle) && bus.start) begin
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (w_accept) begin
      r_bit_cnt  <= r_bit_cnt + c_bit_one;   // wraps to 0 only on the terminal bit
      r_ones_cnt <= w_ones_final;
    end
  end

  // Result registers: loaded only on the terminal cycle so they hold through the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z     <= '0;
      r_sat   <= 1'b0;
      r_early <= 1'b0;
    end else if (w_term) begin
      // The count can reach exactly 2^CNT_WIDTH, so its top bit marks saturation.
      r_z     <= w_ones_final[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_ones_final[CNT_WIDTH-1:0];
      r_sat   <= w_ones_final[CNT_WIDTH];
      r_early <= w_stop;
    end
  end

  assign bus.busy  = w_run;
  assign bus.done  = (r_state == c_st_done);
  assign bus.z     = r_z;
  assign bus.sat   = r_sat;
  assign bus.early = r_early;

endmodule
`default_nettype wire
